// File: rtl/keypad_pkg.sv
// Shared key codes, index-to-code map and FSM encoding
// for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } kp_state_e;

  function automatic logic [3:0] key_code(
    input logic [3:0] idx
  );
    unique case (idx)
      4'd0:  key_code = KEY_1;
      4'd1:  key_code = KEY_2;
      4'd2:  key_code = KEY_3;
      4'd3:  key_code = KEY_A;
      4'd4:  key_code = KEY_4;
      4'd5:  key_code = KEY_5;
      4'd6:  key_code = KEY_6;
      4'd7:  key_code = KEY_B;
      4'd8:  key_code = KEY_7;
      4'd9:  key_code = KEY_8;
      4'd10: key_code = KEY_9;
      4'd11: key_code = KEY_C;
      4'd12: key_code = KEY_STAR;
      4'd13: key_code = KEY_0;
      4'd14: key_code = KEY_HASH;
      default: key_code = KEY_D;
    endcase
  endfunction

  // Lowest set index wins when several keys are down.
  function automatic logic [3:0] lowest_idx(
    input logic [15:0] m
  );
    lowest_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) lowest_idx = 4'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer for the asynchronous keypad rows.
// Resets to all-released (rows are pulled up).
module keypad_sync2 (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/matrix_keypad_scan.sv
// 4x4 active-low keypad scanner with full-scan debounce
// and a single-key press/hold FSM.
module matrix_keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_TICK      = 100_000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       IsPressed,
  output logic [3:0] keyboard_data,
  output logic       key_strobe
);

  localparam int TW = $clog2(SCAN_TICK);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICK - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

  logic [3:0]    row_s;
  logic [TW-1:0] tick;
  logic [1:0]    col;
  logic          slot_end;
  logic          scan_done;
  logic [15:0]   snap;
  logic [15:0]   snap_nxt;
  logic [15:0]   prev_snap;
  logic [15:0]   keymap;
  logic [CW-1:0] stable_cnt;
  logic [CW-1:0] cnt_nxt;

  kp_state_e  state;
  kp_state_e  state_nxt;
  logic       strobe_d;
  logic [3:0] data_d;

  keypad_sync2 u_sync (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .d        (row_in),
    .q        (row_s)
  );

  assign slot_end  = (tick == TICK_LAST);
  assign scan_done = slot_end && (col == 2'd3);
  assign col_out   = ~(4'b0001 << col);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick <= '0;
      col  <= 2'd0;
    end else if (slot_end) begin
      tick <= '0;
      col  <= col + 2'd1;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  // Rows are read on the last cycle of a slot so the column
  // has settled and cleared the synchronizer.
  always_comb begin
    snap_nxt = snap;
    for (int r = 0; r < 4; r++) begin
      snap_nxt[{r[1:0], col}] = ~row_s[r];
    end
  end

  always_comb begin
    cnt_nxt = '0;
    if (snap_nxt == prev_snap) begin
      if (stable_cnt == CNT_MAX) cnt_nxt = stable_cnt;
      else cnt_nxt = stable_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      snap       <= '0;
      prev_snap  <= '0;
      keymap     <= '0;
      stable_cnt <= '0;
    end else if (slot_end) begin
      snap <= snap_nxt;
      if (scan_done) begin
        prev_snap  <= snap_nxt;
        stable_cnt <= cnt_nxt;
        if (cnt_nxt == CNT_MAX) keymap <= snap_nxt;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (|keymap) state_nxt = S_HELD;
      S_HELD: if (keymap == '0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    strobe_d = (state == S_IDLE) && (|keymap);
    data_d   = keyboard_data;
    if (strobe_d) data_d = key_code(lowest_idx(keymap));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_strobe    <= 1'b0;
      keyboard_data <= 4'h0;
    end else begin
      key_strobe    <= strobe_d;
      keyboard_data <= data_d;
    end
  end

  assign IsPressed = (state == S_HELD);

endmodule

// File: doc/matrix_keypad_scan.md
# matrix_keypad_scan

Scans a 4×4 active-low matrix keypad and presents one debounced key to the downstream player/keyboard decoder. A level `IsPressed` and a 4-bit `keyboard_data` code are produced; `keyboard_data` is stable whenever `IsPressed` is high. The block sits between the board keypad pins and the music/electronic-keyboard decoder, on the same 100 MHz `sys_clk` domain.

## Interface
- `SCAN_TICK`, 100_000: `sys_clk` cycles per column slot (1 ms at 100 MHz); must be ≥ 4.
- `DEBOUNCE_SCANS`, 20: number of consecutive identical full scans required before a keymap is accepted; must be ≥ 1.
- `sys_clk` in 1: system clock, 100 MHz.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `row_in` in 4: keypad rows, active-low, pulled up externally, asynchronous to `sys_clk`.
- `col_out` out 4: column drive, one-cold. Driven column is 0; the others are 1.
- `IsPressed` out 1: debounced key-held level.
- `keyboard_data` out 4: key code, valid while `IsPressed`=1.
- `key_strobe` out 1: one-cycle pulse on the cycle `IsPressed` rises.

## Operation
- **Input synchronisation:** `row_in` passes through a 2-FF synchronizer, giving `row_s`.
- **Column scan:**
  - A tick counter (width `$clog2(SCAN_TICK)`) counts 0..`SCAN_TICK`-1, then wraps.
  - On wrap, the column index `col` (2 bits) advances 0→1→2→3→0 and `col_out` = ~(1<<col).
  - Rows are sampled on the last cycle of each slot (tick = `SCAN_TICK`-1), which leaves settling time and the synchronizer delay.
  - Sample: `snap[row*4+col]` = ~`row_s[row]`.
- **Scan completion:** when the col-3 sample is taken, the 16-bit `snap` is a complete scan.
- **Debounce:**
  - If `snap` == `prev_snap`, `stable_cnt` increments, saturating at `DEBOUNCE_SCANS`. Otherwise `stable_cnt` = 0.
  - `prev_snap` <= `snap`.
  - When `stable_cnt` reaches `DEBOUNCE_SCANS`, `keymap` <= `snap`.
- **Key code map (index row*4+col → code):**
  - Row 0: 1, 2, 3, A.
  - Row 1: 4, 5, 6, B.
  - Row 2: 7, 8, 9, C.
  - Row 3: E (*), 0, F (#), D.
- **FSM states:**
  - IDLE: `IsPressed`=0. When `keymap` != 0, latch the code of the lowest set index into `keyboard_data`, pulse `key_strobe`, and go to HELD.
  - HELD: `IsPressed`=1 and `keyboard_data` is frozen. Additional keys and a change of the held key are ignored. When `keymap` == 0, go to IDLE.
- **Multi-key:** the lowest index wins at press time. A new key is accepted only after a full debounced all-released state.
- **Chatter:** any scan differing from the previous one restarts the debounce, so `IsPressed` never toggles on bounce.
- **`keyboard_data` on release:** holds its last value after release; it is only meaningful while `IsPressed`=1.

## Timing
- **Reset values:**
  - `col_out`=4'b1110 (col 0).
  - `IsPressed`=0, `keyboard_data`=0, `key_strobe`=0.
  - Internal state: `snap`/`prev_snap`/`keymap`=0, `stable_cnt`=0, tick=0, FSM=IDLE.
- **Press latency:** a clean press held from a slot boundary raises `IsPressed` after at most (`DEBOUNCE_SCANS`+2)·4·`SCAN_TICK` + 4 cycles, and after at least `DEBOUNCE_SCANS`·4·`SCAN_TICK` cycles.
- **Release latency:** same bounds as press latency.
- **`keymap` to outputs:** `IsPressed`, `keyboard_data` and `key_strobe` update together, one cycle after `keymap` changes.
- **`key_strobe`:** exactly 1 cycle wide, and only on IDLE→HELD.
- **Reset mid-press:** outputs return to their reset values immediately. After reset deassertion, a still-held key must re-debounce fully before `IsPressed` rises.
- **`stable_cnt`:** never wraps.
- **Tick/column counters:** free-running, independent of key state.

## Structure
- Package `keypad_pkg`:
  - Key code localparams: `KEY_0`..`KEY_9`, `KEY_A`..`KEY_D`, `KEY_STAR`=4'hE, `KEY_HASH`=4'hF.
  - The 16-entry index→code map function.
  - FSM state encoding (IDLE, HELD).
- Sub-module `keypad_sync2`: 4-bit 2-FF synchronizer for `row_in`. Everything else lives in one module.

## Test plan
Bench parameters: `SCAN_TICK`=4, `DEBOUNCE_SCANS`=3. The keypad model pulls the row low when the driven column matches the pressed key.

- **Clean press/release:**
  - Press row1/col1 and hold. `IsPressed` rises within (3+2)·16+4 = 84 cycles, `keyboard_data`=4'h5, and `key_strobe` is exactly 1 cycle.
  - Release. `IsPressed` falls within 84 cycles.
- **Bounce:** toggle row0/col0 every 5 cycles for 200 cycles, then hold. No `IsPressed` during toggling; then `IsPressed`=1 with code 4'h1.
- **Two keys:**
  - Press 4'h8 (r2c1), then 4'hA (r0c3) while 8 is held. Code stays 4'h8 and there is no second strobe.
  - Release 8 only. `IsPressed` stays 1.
  - Release all. `IsPressed` falls.
- **Simultaneous:** press r3c0 and r0c2 in the same cycle. Code = 4'h3 (lowest index 2).
- **Reset mid-press:** hold 4'hC and assert `sys_rst_n`=0 for 3 cycles while `IsPressed`=1.
  - During reset: `IsPressed`=0 and `col_out`=4'b1110.
  - After reset: `IsPressed` re-rises no earlier than 3·16 = 48 cycles.
- **Column sweep:** with no key, `col_out` cycles 1110→1101→1011→0111, each held for exactly 4 cycles; `IsPressed` stays 0.
